lfsr_capture_sequencer: RTL and testbench

Single-clock controller that sequences LFSR sample capture into the 8x4 sample buffer and shares the buffer port between the capture writer and a host reader. It generates the LFSR step enable and the buffer write strobes at a divided tick rate, runs single-shot or continuous capture sessions, and arbitrates host read requests around write cycles. It sits between the LFSR, the buffer memory (1-cycle synchronous read) and the host/debug logic.

---
 rtl/lfsr_capture_sequencer.sv | 147 ++++++++++++++
 tb/tb_lfsr_capture_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_capture_sequencer.sv
// rtl/lfsr_capture_sequencer.sv - capture sequencer: tick-paced LFSR sample writes with host read arbitration
module lfsr_capture_sequencer #(
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 4,
   parameter int TICK_DIV = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [DATA_W-1:0] lfsr_data,
   output logic              lfsr_step,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic [ADDR_W:0]   sample_cnt,
   output logic [ADDR_W-1:0] last_addr
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_start_session;
   logic              w_tick;
   logic              w_rd_ack;
   logic [CNT_W-1:0]  r_tick_cnt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_sample_cnt;
   logic [ADDR_W-1:0] r_last_addr;
   logic              r_wrapped;
   logic              r_mode;
   logic              r_rd_valid;

   // A tick only exists while capturing; gating with reset keeps the write from landing during reset
   assign w_tick   = reset && (r_state == S_CAPTURE) && (r_tick_cnt == TICK_LAST);
   // Writes always win the shared buffer port; a blocked read simply retries next cycle
   assign w_rd_ack = reset && rd_req && !w_tick;

   // Session state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: start only honoured outside CAPTURE, stop only inside it
   always_comb begin
      w_state_nxt     = r_state;
      w_start_session = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt     = S_CAPTURE;
               w_start_session = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (stop || (w_tick && !r_mode && (r_wr_ptr == PTR_LAST))) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Session datapath: tick divider, write pointer, sample count, wrap flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tick_cnt   <= '0;
         r_wr_ptr     <= '0;
         r_sample_cnt <= '0;
         r_last_addr  <= '0;
         r_wrapped    <= 1'b0;
         r_mode       <= 1'b0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_ack;
         if (w_start_session) begin
            r_tick_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_sample_cnt <= '0;
            r_wrapped    <= 1'b0;
            r_mode       <= continuous;
         end else if (r_state == S_CAPTURE) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
               r_last_addr <= r_wr_ptr;
               r_wr_ptr    <= r_wr_ptr + 1'b1;
               if (r_sample_cnt != CNT_FULL) begin
                  r_sample_cnt <= r_sample_cnt + 1'b1;
               end
               // A full count with the pointer back at 0 means entry 0 is being overwritten
               if ((r_sample_cnt == CNT_FULL) && (r_wr_ptr == '0)) begin
                  r_wrapped <= 1'b1;
               end
            end
         end
      end
   end

   // Buffer port mux: write address on ticks, host address on acks, otherwise idle zeros
   always_comb begin
      mem_we    = w_tick;
      lfsr_step = w_tick;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_tick) begin
         mem_addr  = r_wr_ptr;
         mem_wdata = lfsr_data;
      end else if (w_rd_ack) begin
         mem_addr = rd_addr;
      end
   end

   assign rd_ack     = w_rd_ack;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = mem_rdata;
   assign busy       = (r_state == S_CAPTURE);
   assign done       = (r_state == S_DONE);
   assign wrapped    = r_wrapped;
   assign sample_cnt = r_sample_cnt;
   assign last_addr  = r_last_addr;

endmodule

// File: tb/tb_lfsr_capture_sequencer.sv
// tb/tb_lfsr_capture_sequencer.sv - self-checking bench for lfsr_capture_sequencer
module tb_lfsr_capture_sequencer;

   localparam int DEPTH    = 8;
   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 4;
   localparam int TICK_DIV = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stop;
   logic              continuous;
   logic [DATA_W-1:0] lfsr_data;
   logic              lfsr_step;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic              wrapped;
   logic [ADDR_W:0]   sample_cnt;
   logic [ADDR_W-1:0] last_addr;

   always #5 clk = ~clk;

   lfsr_capture_sequencer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
      .lfsr_data(lfsr_data), .lfsr_step(lfsr_step), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
      .wrapped(wrapped), .sample_cnt(sample_cnt), .last_addr(last_addr)
   );

   // Sample buffer with 1-cycle synchronous read
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Reference model: session described as cycle count and number of writes
   bit              m_valid = 0;
   bit              m_busy, m_done, m_cont, m_wrapped, m_rdv, m_rd_known;
   int              m_cyc, m_writes, m_last;
   logic [DATA_W-1:0] m_rd_exp;
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit              m_known [DEPTH];

   int tests = 0;
   int fails = 0;
   int cyc_no = 0;
   int steps_seen, we_seen, first_we, start_cyc;
   bit rand_rd = 0;
   int obs_we, obs_ack, obs_addr, obs_valid, obs_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit tick_now();
      return m_busy && (m_cyc % TICK_DIV == 0);
   endfunction

   task automatic cycle();
      bit tick, ack;
      int waddr, exp_addr, exp_cnt;
      lfsr_data = DATA_W'($urandom);
      if (rand_rd && !rd_req && ($urandom_range(0, 3) == 0)) begin
         rd_req  = 1'b1;
         rd_addr = ADDR_W'($urandom);
      end
      @(negedge clk);
      tick     = reset && tick_now();
      ack      = reset && rd_req && !tick;
      waddr    = m_writes % DEPTH;
      exp_addr = tick ? waddr : (ack ? int'(rd_addr) : 0);
      exp_cnt  = (m_writes > DEPTH) ? DEPTH : m_writes;
      chk("mem_we", mem_we, tick);
      chk("lfsr_step", lfsr_step, tick);
      chk("rd_ack", rd_ack, ack);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, tick ? lfsr_data : 0);
      if (m_valid) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("wrapped", wrapped, m_wrapped);
         chk("sample_cnt", sample_cnt, exp_cnt);
         chk("last_addr", last_addr, m_last);
         chk("rd_valid", rd_valid, m_rdv);
         if (m_rdv && reset && m_rd_known) chk("rd_data", rd_data, m_rd_exp);
      end
      obs_we = mem_we; obs_ack = rd_ack; obs_addr = mem_addr;
      obs_valid = rd_valid; obs_rdata = rd_data;
      if (mem_we) begin
         we_seen++;
         if (first_we < 0) first_we = cyc_no;
      end
      if (lfsr_step) steps_seen++;
      @(posedge clk);
      if (!reset) begin
         m_valid = 1; m_busy = 0; m_done = 0; m_cont = 0; m_wrapped = 0; m_rdv = 0;
         m_cyc = 0; m_writes = 0; m_last = 0;
      end else begin
         m_rdv = ack;
         if (ack) begin
            m_rd_exp   = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
         end
         if (tick) begin
            m_mem[waddr]   = lfsr_data;
            m_known[waddr] = 1;
            if (m_writes >= DEPTH) m_wrapped = 1;
            m_last = waddr;
            m_writes++;
         end
         if (m_busy) begin
            if (stop || (tick && !m_cont && m_writes == DEPTH)) begin
               m_busy = 0; m_done = 1;
            end else begin
               m_cyc++;
            end
         end else if (start) begin
            m_busy = 1; m_done = 0; m_cyc = 1; m_writes = 0; m_wrapped = 0;
            m_cont = continuous;
         end
      end
      cyc_no++;
      #1;
      if (ack) rd_req = 1'b0;
   endtask

   task automatic begin_session(input bit cont);
      continuous = cont;
      start      = 1'b1;
      start_cyc  = cyc_no;
      cycle();
      start      = 1'b0;
      continuous = 1'b0;
   endtask

   task automatic run_to_tick(input int writes, input string tag);
      for (int n = 0; n < 400 && !(tick_now() && m_writes == writes); n++) cycle();
      chk(tag, tick_now() && m_writes == writes, 1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
      reset = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      rd_req = 1'b0; rd_addr = '0; lfsr_data = '0;
      first_we = -1; steps_seen = 0; we_seen = 0;
      #1;
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      chk("rst_busy", busy, 0);
      chk("rst_cnt", sample_cnt, 0);

      // Single-shot session
      steps_seen = 0; first_we = -1;
      begin_session(1'b0);
      for (int n = 0; n < 200 && !done; n++) cycle();
      chk("ss_done", done, 1);
      chk("ss_busy", busy, 0);
      chk("ss_first_we", first_we - start_cyc, TICK_DIV);
      chk("ss_steps", steps_seen, DEPTH);
      chk("ss_cnt", sample_cnt, DEPTH);
      chk("ss_last", last_addr, DEPTH - 1);
      chk("ss_wrapped", wrapped, 0);

      // Continuous session with random host reads
      rand_rd = 1;
      begin_session(1'b1);
      for (int n = 0; n < 400 && m_writes < 10; n++) cycle();
      chk("cont_writes", m_writes, 10);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      cycle();
      chk("cont_wrapped", wrapped, 1);
      chk("cont_cnt", sample_cnt, DEPTH);
      chk("cont_last", last_addr, 1);
      chk("cont_done", done, 1);
      rand_rd = 0;
      for (int n = 0; n < 8 && rd_req; n++) cycle();

      // Read request colliding with a write tick
      begin_session(1'b0);
      run_to_tick(4, "arb_reach");
      rd_req = 1'b1; rd_addr = 3'd3;
      cycle();
      chk("arb_blocked", obs_ack, 0);
      chk("arb_tick_we", obs_we, 1);
      cycle();
      chk("arb_ack", obs_ack, 1);
      chk("arb_addr", obs_addr, 3);
      cycle();
      chk("arb_valid", obs_valid, 1);
      chk("arb_data", obs_rdata, m_mem[3]);
      for (int n = 0; n < 200 && !done; n++) cycle();
      chk("arb_done", done, 1);

      // Stop coincident with the fifth write
      begin_session(1'b0);
      run_to_tick(4, "stop_reach");
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      chk("stop_we", obs_we, 1);
      we_seen = 0;
      for (int n = 0; n < 30; n++) cycle();
      chk("stop_nowrite", we_seen, 0);
      chk("stop_cnt", sample_cnt, 5);
      chk("stop_last", last_addr, 4);
      chk("stop_done", done, 1);

      // Reset landing on a write tick
      begin_session(1'b0);
      run_to_tick(2, "rst_reach");
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      chk("rstmid_we", obs_we, 0);
      cycle();
      chk("rstmid_busy", busy, 0);
      chk("rstmid_cnt", sample_cnt, 0);
      chk("rstmid_last", last_addr, 0);

      // stop in IDLE ignored, start in CAPTURE ignored
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      cycle();
      chk("idle_stop_busy", busy, 0);
      chk("idle_stop_done", done, 0);
      begin_session(1'b0);
      run_to_tick(0, "restart_reach");
      cycle();
      chk("restart_addr0", last_addr, 0);
      for (int n = 0; n < 5; n++) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      run_to_tick(1, "ign_reach");
      cycle();
      chk("ign_start_last", last_addr, 1);
      chk("ign_start_cnt", sample_cnt, 2);
      for (int n = 0; n < 200 && !done; n++) cycle();
      chk("final_done", done, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
